// File: rtl/tank_gfx_pkg.sv
// -----------------------------------------------------------------------------
// tank_gfx_pkg
// Shared graphics types and helpers for the tank sprite pipeline.
//   rgb444_t        : 4-bit-per-channel colour
//   pix_tag_t       : per-pixel side information carried alongside the ROM read
//   SCREEN_W/H      : visible raster size
//   spr_texel()     : sprite image content (palette index for a texel)
//   palette_lookup(): palette index -> colour, selectable per sprite set
// -----------------------------------------------------------------------------
package tank_gfx_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic    in_box;
    logic    blank;
    rgb444_t bg;
  } pix_tag_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Sprite image: a diagonal index ramp. The caller truncates the result to
  // its index width, so index 0 (transparent by default) recurs regularly.
  function automatic int unsigned spr_texel(int unsigned row, int unsigned col);
    return col + 3 * row;
  endfunction

  // Set 1 is a grey ramp; every other set value selects the default palette.
  function automatic rgb444_t palette_lookup(int unsigned set, int unsigned idx);
    logic [3:0] i4;
    rgb444_t    c;
    i4 = 4'(idx);
    if (set == 1) begin
      c.r = i4;
      c.g = i4;
      c.b = i4;
    end else begin
      c.r = i4;
      c.g = ~i4;
      c.b = {i4[1:0], i4[3:2]};
    end
    return c;
  endfunction

endpackage

// File: rtl/tank_sprite_rom.sv
// -----------------------------------------------------------------------------
// tank_sprite_rom
// Synchronous sprite ROM, SPR_W*SPR_H entries of IDX_BITS, read latency
// ROM_LAT cycles. Contents come from tank_gfx_pkg::spr_texel, so the image is
// constant logic rather than a loaded memory.
// Ports:
//   clk_i   in  1       read clock
//   addr_i  in  ADDR_W  {row, col}
//   data_o  out IDX_BITS palette index, ROM_LAT cycles after addr_i
// -----------------------------------------------------------------------------
module tank_sprite_rom
  import tank_gfx_pkg::*;
#(
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int IDX_BITS = 4,
  parameter int ROM_LAT  = 1,
  parameter int ADDR_W   = $clog2(SPR_W) + $clog2(SPR_H)
) (
  input  logic                clk_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [IDX_BITS-1:0] data_o
);

  localparam int CW = $clog2(SPR_W);

  logic [ADDR_W-1:CW]   row_w;
  logic [CW-1:0]        col_w;
  logic [IDX_BITS-1:0]  word_d;
  logic [IDX_BITS-1:0]  pipe_q [ROM_LAT];

  assign row_w  = addr_i[ADDR_W-1:CW];
  assign col_w  = addr_i[CW-1:0];
  assign word_d = IDX_BITS'(spr_texel(32'(row_w), 32'(col_w)));

  // Data path only; no reset needed since the caller qualifies every read.
  always_ff @(posedge clk_i) begin
    pipe_q[0] <= word_d;
    for (int k = 1; k < ROM_LAT; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign data_o = pipe_q[ROM_LAT-1];

endmodule

// File: rtl/tank_sprite_layer.sv
// -----------------------------------------------------------------------------
// tank_sprite_layer
// Per-pixel sprite overlay on the VGA path. One palettized sprite is placed at
// a per-frame latched position with 1<<scale_log2 magnification; texels equal
// to TRANSP_IDX show the background. Latency from DrawX/DrawY/bg/blank to the
// outputs is ROM_LAT+1 cycles regardless of hit.
// Ports:
//   vga_clk, reset_n                 clock, async active-low reset
//   DrawX, DrawY [9:0]               current pixel
//   blank                            1 = active video
//   frame_start                      shadow register load strobe
//   spr_en, pos_x, pos_y, scale_log2 live placement (shadowed on frame_start)
//   spr_hflip                        horizontal mirror (TANK_SPR_HFLIP_EN only)
//   bg_red/green/blue [3:0]          background colour
//   red/green/blue [3:0]             composited colour (registered)
//   sprite_hit                       output pixel is an opaque sprite texel
// Build option: define TANK_SPR_HFLIP_EN to add the spr_hflip input.
// reset_n is expected to deassert synchronously to vga_clk (upstream
// synchroniser); assertion may be fully asynchronous.
// -----------------------------------------------------------------------------
module tank_sprite_layer
  import tank_gfx_pkg::*;
#(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int IDX_BITS   = 4,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_IDX = 0,
  parameter int SPRITE_SET = 0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       frame_start,
  input  logic       spr_en,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [1:0] scale_log2,
`ifdef TANK_SPR_HFLIP_EN
  input  logic       spr_hflip,
`endif
  input  logic [3:0] bg_red,
  input  logic [3:0] bg_green,
  input  logic [3:0] bg_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       sprite_hit
);

  localparam int CW     = $clog2(SPR_W);
  localparam int RW     = $clog2(SPR_H);
  localparam int ADDR_W = CW + RW;

  // ---------------------------------------------------------------- shadows
  logic       en_q,    en_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic [1:0] scale_q, scale_d;
  logic       hflip_q, hflip_d;

  always_comb begin
    en_d    = en_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    scale_d = scale_q;
    hflip_d = hflip_q;
    if (frame_start) begin
      en_d    = spr_en;
      pos_x_d = pos_x;
      pos_y_d = pos_y;
      scale_d = scale_log2;
`ifdef TANK_SPR_HFLIP_EN
      hflip_d = spr_hflip;
`else
      hflip_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      scale_q <= '0;
      hflip_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      scale_q <= scale_d;
      hflip_q <= hflip_d;
    end
  end

  // ------------------------------------------------- stage 0: box + address
  logic [10:0]       dx, dy;
  logic [9:0]        dx_sh, dy_sh;
  logic              in_box;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] rom_addr;

  assign dx    = {1'b0, DrawX} - {1'b0, pos_x_q};
  assign dy    = {1'b0, DrawY} - {1'b0, pos_y_q};
  // For non-negative offsets, dx < (SPR_W<<scale) is the same as the shifted
  // offset fitting in the column field, so the upper bits must be zero.
  assign dx_sh = dx[9:0] >> scale_q;
  assign dy_sh = dy[9:0] >> scale_q;

  assign in_box = en_q && !dx[10] && !dy[10]
               && (dx_sh[9:CW] == '0) && (dy_sh[9:RW] == '0)
               && (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));

  // Mirroring SPR_W-1-c on a power-of-two field is a bitwise inversion.
  assign col      = hflip_q ? ~dx_sh[CW-1:0] : dx_sh[CW-1:0];
  assign rom_addr = {dy_sh[RW-1:0], col};

  // ------------------------------------------------------------- ROM stage
  logic [IDX_BITS-1:0] rom_data;

  tank_sprite_rom #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .IDX_BITS (IDX_BITS),
    .ROM_LAT  (ROM_LAT),
    .ADDR_W   (ADDR_W)
  ) u_rom (
    .clk_i  (vga_clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Side information travels in lockstep with the ROM read.
  pix_tag_t tag_d;
  pix_tag_t dly_q [ROM_LAT];

  always_comb begin
    tag_d.in_box = in_box;
    tag_d.blank  = blank;
    tag_d.bg.r   = bg_red;
    tag_d.bg.g   = bg_green;
    tag_d.bg.b   = bg_blue;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      dly_q[0] <= tag_d;
      for (int k = 1; k < ROM_LAT; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
    end
  end

  // ------------------------------------------------ palette + composite out
  pix_tag_t tail;
  rgb444_t  pal;
  rgb444_t  rgb_d, rgb_q;
  logic     hit_d, hit_q;

  assign tail = dly_q[ROM_LAT-1];
  assign pal  = palette_lookup(SPRITE_SET, 32'(rom_data));

  always_comb begin
    rgb_d = '0;
    hit_d = 1'b0;
    if (!tail.blank) begin
      rgb_d = '0;
      hit_d = 1'b0;
    end else if (tail.in_box && (rom_data != IDX_BITS'(TRANSP_IDX))) begin
      rgb_d = pal;
      hit_d = 1'b1;
    end else begin
      rgb_d = tail.bg;
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
      hit_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
    end
  end

  assign red        = rgb_q.r;
  assign green      = rgb_q.g;
  assign blue       = rgb_q.b;
  assign sprite_hit = hit_q;

endmodule

// File: tb/tb_tank_sprite_layer.sv
// -----------------------------------------------------------------------------
// tb_tank_sprite_layer
// Random and directed stimulus against a pixel-level reference model of the
// sprite overlay. Expected outputs are queued per clock and released after the
// pipeline latency; a few literal pixel values pin the model.
// -----------------------------------------------------------------------------
module tb_tank_sprite_layer;

  localparam int L  = 2;   // ROM_LAT under test
  localparam int SW = 32;
  localparam int SH = 32;

  // ------------------------------------------------------ clock and reset
  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, frame_start, spr_en, spr_hflip;
  logic [1:0] scale_log2;
  logic [3:0] bg_red, bg_green, bg_blue, red, green, blue;
  logic       sprite_hit;

  tank_sprite_layer #(
    .SPR_W(SW), .SPR_H(SH), .IDX_BITS(4), .ROM_LAT(L), .TRANSP_IDX(0), .SPRITE_SET(0)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .spr_en      (spr_en),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .scale_log2  (scale_log2),
`ifdef TANK_SPR_HFLIP_EN
    .spr_hflip   (spr_hflip),
`endif
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .sprite_hit  (sprite_hit)
  );

  // ------------------------------------------------------------ scoreboard
  logic [12:0] exp_q[$];
  logic [12:0] cur_exp;
  int          n_vec  = 0;
  int          n_fail = 0;

  // Model shadow placement.
  bit m_en;
  int m_px, m_py, m_sc;
  bit m_hf;

  // Pixel rule from the behavioural description: {hit, r, g, b}.
  function automatic logic [12:0] pix_model(int x, int y, bit blk, logic [11:0] bg,
                                            bit en, int px, int py, int sc, bit hf);
    int dx, dy, col, row, idx;
    logic [12:0] r;
    if (!blk) return 13'h0;
    dx = x - px;
    dy = y - py;
    if (en && dx >= 0 && dy >= 0 && dx < (SW << sc) && dy < (SH << sc) && x < 640 && y < 480) begin
      col = dx / (1 << sc);
      row = dy / (1 << sc);
      if (hf) col = SW - 1 - col;
      idx = (col + 3 * row) % 16;
      if (idx != 0) begin
        r = {1'b1, 4'(idx), 4'(15 - idx), 4'((idx % 4) * 4 + idx / 4)};
        return r;
      end
    end
    return {1'b0, bg};
  endfunction

  task automatic model_step();
    logic [12:0] e;
    if (!reset_n) begin
      m_en = 0; m_px = 0; m_py = 0; m_sc = 0; m_hf = 0;
      exp_q = {};
      for (int k = 0; k < L; k++) exp_q.push_back(13'h0);
      cur_exp = 13'h0;
    end else begin
      e = pix_model(int'(DrawX), int'(DrawY), blank, {bg_red, bg_green, bg_blue},
                    m_en, m_px, m_py, m_sc, m_hf);
      if (frame_start) begin
        m_en = spr_en; m_px = int'(pos_x); m_py = int'(pos_y); m_sc = int'(scale_log2);
`ifdef TANK_SPR_HFLIP_EN
        m_hf = spr_hflip;
`endif
      end
      exp_q.push_back(e);
      cur_exp = exp_q.pop_front();
    end
  endtask

  task automatic check_out();
    logic [12:0] act;
    act = {sprite_hit, red, green, blue};
    n_vec++;
    if (act !== cur_exp) begin
      n_fail++;
      if (n_fail < 20)
        $display("FAIL pixel t=%0t got %h expected %h", $time, act, cur_exp);
    end
  endtask

  task automatic check_lit(string name, logic [12:0] exp);
    logic [12:0] act;
    act = {sprite_hit, red, green, blue};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------- drivers
  task automatic cycle();
    @(posedge vga_clk);
    model_step();
    @(negedge vga_clk);
    check_out();
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic place(bit en, int px, int py, int sc, bit hf);
    frame_start = 1; spr_en = en; pos_x = 10'(px); pos_y = 10'(py);
    scale_log2 = 2'(sc); spr_hflip = hf; blank = 0;
    cycle();
    frame_start = 0;
  endtask

  // Present one pixel long enough for it to reach the outputs.
  task automatic pix(int x, int y, bit blk);
    DrawX = 10'(x); DrawY = 10'(y); blank = blk;
    hold(L + 2);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int fx, fy, fs;
    reset_n = 0; DrawX = 0; DrawY = 0; blank = 1; frame_start = 0;
    spr_en = 0; pos_x = 0; pos_y = 0; scale_log2 = 0; spr_hflip = 0;
    bg_red = 4'hA; bg_green = 4'hA; bg_blue = 4'hA;

    // Reset and fill latency.
    hold(3);
    check_lit("reset_out", 13'h0);
    reset_n = 1;
    hold(L);
    check_lit("fill_still_zero", 13'h0);
    cycle();
    check_lit("first_bg", 13'h0AAA);

    // Placement at (100,50), scale 1.
    bg_red = 4'h5; bg_green = 4'hA; bg_blue = 4'h3;
    place(1, 100, 50, 0, 0);
    pix(100, 50, 1);  check_lit("addr0_transparent", 13'h05A3);
    pix(131, 50, 1);  check_lit("addr31", 13'h1F0F);
    pix(132, 50, 1);  check_lit("past_right_edge", 13'h05A3);
    pix(131, 50, 0);  check_lit("blank_opaque", 13'h0000);

    // Tear-free: live pos_x moves mid-frame, shadow holds.
    pos_x = 10'd200;
    pix(131, 50, 1);  check_lit("tear_old_pos", 13'h1F0F);
    pix(231, 50, 1);  check_lit("tear_new_pos_ignored", 13'h05A3);
    place(1, 200, 50, 0, 0);
    pix(231, 50, 1);  check_lit("new_pos_after_fs", 13'h1F0F);

    // Scale x4 at origin.
    place(1, 0, 0, 2, 0);
    pix(0, 4, 1);     check_lit("scale_col0_x0", 13'h13CC);
    pix(3, 4, 1);     check_lit("scale_col0_x3", 13'h13CC);
    pix(4, 4, 1);     check_lit("scale_col1", 13'h14B1);
    pix(127, 4, 1);   check_lit("scale_col31", 13'h12D8);
    pix(128, 4, 1);   check_lit("scale_past_edge", 13'h05A3);

    // Clipping near bottom-right.
    place(1, 630, 470, 0, 0);
    pix(639, 479, 1); check_lit("clip_corner", 13'h14B1);
    pix(629, 479, 1); check_lit("clip_left_of", 13'h05A3);
    pix(640, 479, 1); check_lit("clip_offscreen", 13'h05A3);

`ifdef TANK_SPR_HFLIP_EN
    place(1, 100, 50, 0, 1);
    pix(100, 50, 1);  check_lit("hflip_col31", 13'h1F0F);
`endif

    // Randomized frames; live placement wanders mid-frame.
    for (int f = 0; f < 12; f++) begin
      fx = $urandom_range(0, 680);
      fy = $urandom_range(0, 500);
      fs = $urandom_range(0, 3);
      place($urandom_range(0, 9) != 0, fx, fy, fs, $urandom_range(0, 1));
      if (f == 6) begin
        reset_n = 0;
        hold(2);
        reset_n = 1;
      end
      for (int p = 0; p < 250; p++) begin
        if ($urandom_range(0, 4) == 0) begin
          DrawX = 10'($urandom_range(0, 1023));
          DrawY = 10'($urandom_range(0, 1023));
        end else begin
          DrawX = 10'(fx + $urandom_range(0, (SW << fs) + 8) - 4);
          DrawY = 10'(fy + $urandom_range(0, (SH << fs) + 8) - 4);
        end
        blank    = $urandom_range(0, 9) != 0;
        bg_red   = 4'($urandom_range(0, 15));
        bg_green = 4'($urandom_range(0, 15));
        bg_blue  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) begin
          spr_en = $urandom_range(0, 1); pos_x = 10'($urandom_range(0, 700));
          pos_y = 10'($urandom_range(0, 500)); scale_log2 = 2'($urandom_range(0, 3));
          spr_hflip = $urandom_range(0, 1);
        end
        frame_start = ($urandom_range(0, 199) == 0);
        cycle();
        frame_start = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
